tap_mac_seq: RTL and testbench
==============================

# tap_mac_seq

Four-tap multiply-accumulate sequencer that sits directly downstream of the 4:1 operand mux in the filter datapath. Drives the mux select, consumes the selected 32-bit sample on each cycle, multiplies it by a programmable signed coefficient, and accumulates one filter output per pass. Results leave through a valid/ready handshake toward the write-back stage.

## Interface

Parameters:

- DATA_W, 32, sample width, equal to the mux data width
- COEF_W, 16, coefficient width
- ACC_W, DATA_W+COEF_W+2, accumulator and result width

Ports:

- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- coef_we  in  1  coefficient write strobe
- coef_addr  in  2  coefficient index 0..3
- coef_wdata  in  COEF_W  signed coefficient value
- start  in  1  request one 4-tap pass
- busy  out  1  high in RUN and DONE
- sel  out  2  mux select, drives the mux `s` input
- tap_data  in  DATA_W  signed sample from the mux `y` output
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result
- res_data  out  ACC_W  signed accumulated result

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE:
  - sel=0, busy=0.
  - If start=1 at an edge: clear acc, set tap counter k=0, go to RUN.
- RUN:
  - sel=k.
  - Each edge: acc <= acc + sext(tap_data * coef[k]), and k increments.
  - The edge with k=3 moves the FSM to DONE.
- DONE:
  - sel=0, res_valid=1, res_data=acc, both held stable.
  - At the edge where res_ready=1, go to IDLE and drop res_valid.
- start is ignored in RUN and DONE. It is also ignored on the edge that completes the DONE handshake, so a new pass needs start high while in IDLE.
- Arithmetic:
  - tap_data and coef are two's-complement.
  - The product is a full-precision DATA_W+COEF_W signed value, sign-extended to ACC_W.
  - The accumulator wraps modulo 2^ACC_W. With default widths, 4 taps cannot overflow.
- Coefficient writes:
  - A write occurs on an edge with coef_we=1 and is accepted in any state.
  - A RUN cycle reading coef[k] on the same edge as a write to coef[k] uses the old value. The new value applies from the next cycle.
- Reset (rst_n low, immediate, any state):
  - state=IDLE, sel=0, busy=0, res_valid=0, res_data=0, acc=0, k=0.
  - All four coefficients are cleared to 0.
  - A reset in the middle of a pass discards that pass, and no result is produced.

## Timing

- Call the edge where start is sampled in IDLE E0.
- sel takes values 0, 1, 2, 3 in the cycles after E0, E1, E2 and E3.
- Taps accumulate on edges E1..E4. res_valid rises after E4.
- Start-to-result latency is 4 cycles. Minimum pass period is 6 cycles: 4 RUN, at least 1 DONE, 1 IDLE.
- tap_data must settle combinationally from sel within the same cycle, since the mux has no register.
- res_data and res_valid are registered outputs. No output has a combinational path from res_ready or start.

## Test plan

- Coefs {1,1,1,1}, mux I0..I3 = 0, 1, 2, 3, pulse start:
  - sel steps 0, 1, 2, 3 on consecutive cycles.
  - res_valid rises 4 cycles after the start edge with res_data=6.
  - With res_ready=1, the FSM returns to IDLE on the next edge.
- Coefs {2,-1,3,0}, I0..I3 = 10, 20, 30, 40 -> res_data=90.
- Coefs all 0x7FFF, I0..I3 all 0xFFFFFFFF (-1) -> res_data = -131068, sign-extended to ACC_W.
- Backpressure:
  - Hold res_ready=0 for 5 cycles after res_valid, and pulse start during that window.
  - res_valid and res_data stay constant, and busy=1 throughout.
  - The start pulse is ignored.
  - When res_ready=1, exactly one result transfers and no second pass starts.
- Reset mid-pass:
  - Drive rst_n low while sel=2.
  - All outputs go to 0 immediately.
  - After release, coefs read 0, and a re-programmed pass with coefs {1,1,1,1} and inputs 0..3 returns res_data=6.
- Coefficient write collision:
  - Write coef[1]=5 on the same edge that consumes tap 1 (old coef=1, I1=1), with I0..I3 = 0..3 and coef[0], coef[2], coef[3] = 1.
  - That pass returns 6.
  - The next pass returns 10 (0 + 5 + 2 + 3).

Source files
------------

// File: rtl/tap_mac_if.sv
// Handshake and bus bundle between the tap MAC sequencer and its surroundings:
// coefficient programming, start/busy control, mux select/sample and result.
interface tap_mac_if #(
  parameter int DATA_W = 32,
  parameter int COEF_W = 16,
  parameter int ACC_W  = DATA_W + COEF_W + 2
);
  logic              coef_we;
  logic [1:0]        coef_addr;
  logic [COEF_W-1:0] coef_wdata;
  logic              start;
  logic              busy;
  logic [1:0]        sel;
  logic [DATA_W-1:0] tap_data;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_data;

  // Driver side: programs coefficients, starts passes, supplies the muxed sample.
  modport master (
    output coef_we, coef_addr, coef_wdata, start, tap_data, res_ready,
    input  busy, sel, res_valid, res_data
  );

  // Sequencer side.
  modport slave (
    input  coef_we, coef_addr, coef_wdata, start, tap_data, res_ready,
    output busy, sel, res_valid, res_data
  );
endinterface

// File: rtl/tap_mac_seq.sv
// Four-tap multiply-accumulate sequencer. Steps the operand mux select through
// taps 0..3, accumulates sample*coef for each, then offers the sum on a
// valid/ready handshake. One pass per start pulse taken in IDLE.
module tap_mac_seq #(
  parameter int DATA_W = 32,
  parameter int COEF_W = 16,
  parameter int ACC_W  = DATA_W + COEF_W + 2
) (
  input  logic     clk,
  input  logic     rst_n,
  tap_mac_if.slave bus
);
  localparam int PROD_W = DATA_W + COEF_W;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        k_q;
  logic [ACC_W-1:0]  acc_q;
  logic [COEF_W-1:0] coef_q [4];

  logic signed [PROD_W-1:0] prod;
  logic [ACC_W-1:0]         prod_ext;

  // Full-precision signed product of the current tap, sign-extended to the
  // accumulator. coef_q is read before any same-edge write lands, so a write
  // colliding with its tap takes effect only from the next cycle.
  assign prod     = $signed(bus.tap_data) * $signed(coef_q[k_q]);
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start)     state_d = RUN;
      RUN:     if (k_q == 2'd3)   state_d = DONE;
      DONE:    if (bus.res_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Tap counter and accumulator; acc doubles as the held result in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q   <= 2'd0;
      acc_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          k_q   <= 2'd0;
          acc_q <= '0;
        end
        RUN: begin
          k_q   <= k_q + 2'd1;
          acc_q <= acc_q + prod_ext;
        end
        default: ;
      endcase
    end
  end

  // Coefficient bank, writable in any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) coef_q[i] <= '0;
    end else if (bus.coef_we) begin
      coef_q[bus.coef_addr] <= bus.coef_wdata;
    end
  end

  // Outputs decode from registers only; nothing depends on start or res_ready.
  assign bus.sel       = (state_q == RUN) ? k_q : 2'd0;
  assign bus.busy      = (state_q != IDLE);
  assign bus.res_valid = (state_q == DONE);
  assign bus.res_data  = acc_q;
endmodule

// File: tb/tb_tap_mac_seq.sv
// Bench for tap_mac_seq: directed scenarios plus randomized passes checked
// against a sum-of-products reference model.
module tb_tap_mac_seq;
  localparam int DATA_W = 32;
  localparam int COEF_W = 16;
  localparam int ACC_W  = DATA_W + COEF_W + 2;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic signed [DATA_W-1:0] mux_in [4];
  logic signed [COEF_W-1:0] coef_m [4];

  tap_mac_if #(.DATA_W(DATA_W), .COEF_W(COEF_W)) bus ();

  tap_mac_seq #(.DATA_W(DATA_W), .COEF_W(COEF_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Unregistered 4:1 operand mux upstream of the sequencer.
  assign bus.tap_data = mux_in[bus.sel];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed sum of products, wrapped to ACC_W.
  function automatic logic [ACC_W-1:0] model();
    longint s = 0;
    for (int i = 0; i < 4; i++) s = s + longint'(mux_in[i]) * longint'(coef_m[i]);
    return s[ACC_W-1:0];
  endfunction

  task automatic set_coef(input int i, input logic signed [COEF_W-1:0] v);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = i[1:0];
    bus.coef_wdata = v;
    @(negedge clk);
    bus.coef_we = 1'b0;
    coef_m[i]   = v;
  endtask

  task automatic set_all(input logic signed [COEF_W-1:0] c0, c1, c2, c3,
                         input logic signed [DATA_W-1:0] d0, d1, d2, d3);
    set_coef(0, c0); set_coef(1, c1); set_coef(2, c2); set_coef(3, c3);
    mux_in[0] = d0; mux_in[1] = d1; mux_in[2] = d2; mux_in[3] = d3;
  endtask

  // One full pass: start, four RUN cycles, hold in DONE for `hold` cycles
  // (optionally poking start), then a single handshake back to IDLE.
  task automatic run_pass(input string tag, input int hold, input bit poke,
                          input logic [ACC_W-1:0] exp);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check({tag, " sel"}, 64'(bus.sel), 64'(i));
      check({tag, " run busy"}, 64'(bus.busy), 64'd1);
      check({tag, " run valid"}, 64'(bus.res_valid), 64'd0);
      @(negedge clk);
    end
    check({tag, " valid"}, 64'(bus.res_valid), 64'd1);
    check({tag, " data"}, 64'(bus.res_data), 64'(exp));
    for (int j = 0; j < hold; j++) begin
      bus.start = poke && (j == 2);
      @(negedge clk);
      check({tag, " hold valid"}, 64'(bus.res_valid), 64'd1);
      check({tag, " hold data"}, 64'(bus.res_data), 64'(exp));
      check({tag, " hold busy"}, 64'(bus.busy), 64'd1);
      check({tag, " hold sel"}, 64'(bus.sel), 64'd0);
    end
    bus.res_ready = 1'b1;
    bus.start     = poke;
    @(negedge clk);
    bus.res_ready = 1'b0;
    bus.start     = 1'b0;
    check({tag, " ack valid"}, 64'(bus.res_valid), 64'd0);
    check({tag, " ack busy"}, 64'(bus.busy), 64'd0);
    @(negedge clk);
    check({tag, " idle busy"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.coef_we    = 1'b0;
    bus.coef_addr  = 2'd0;
    bus.coef_wdata = '0;
    bus.start      = 1'b0;
    bus.res_ready  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mux_in[i] = '0;
      coef_m[i] = '0;
    end

    // Reset state
    @(negedge clk);
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst sel", 64'(bus.sel), 64'd0);
    check("rst valid", 64'(bus.res_valid), 64'd0);
    check("rst data", 64'(bus.res_data), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic pass, ones times ramp
    set_all(1, 1, 1, 1, 0, 1, 2, 3);
    run_pass("t1", 0, 1'b0, 50'd6);

    // Mixed-sign coefficients
    set_all(2, -1, 3, 0, 10, 20, 30, 40);
    run_pass("t2", 0, 1'b0, 50'd90);

    // Max coef times -1 samples, negative sign-extended result
    set_all(16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF, -1, -1, -1, -1);
    run_pass("t3", 0, 1'b0, ACC_W'(-131068));

    // Backpressure with ignored start pulses
    set_all(1, 1, 1, 1, 0, 1, 2, 3);
    run_pass("t4", 5, 1'b1, 50'd6);

    // Reset while sel=2 discards the pass and clears coefficients
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5 sel before rst", 64'(bus.sel), 64'd2);
    rst_n = 1'b0;
    #1;
    check("t5 rst busy", 64'(bus.busy), 64'd0);
    check("t5 rst sel", 64'(bus.sel), 64'd0);
    check("t5 rst valid", 64'(bus.res_valid), 64'd0);
    check("t5 rst data", 64'(bus.res_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) coef_m[i] = '0;
    @(negedge clk);
    check("t5 no result", 64'(bus.res_valid), 64'd0);
    run_pass("t5 zero coefs", 0, 1'b0, 50'd0);
    set_all(1, 1, 1, 1, 0, 1, 2, 3);
    run_pass("t5 reprog", 0, 1'b0, 50'd6);

    // Write coef[1] on the edge that consumes tap 1
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("t6 sel1", 64'(bus.sel), 64'd1);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = 2'd1;
    bus.coef_wdata = 16'sd5;
    @(negedge clk);
    bus.coef_we = 1'b0;
    coef_m[1]   = 16'sd5;
    @(negedge clk);
    @(negedge clk);
    check("t6 valid", 64'(bus.res_valid), 64'd1);
    check("t6 data old coef", 64'(bus.res_data), 64'd6);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("t6 ack busy", 64'(bus.busy), 64'd0);
    run_pass("t6 new coef", 0, 1'b0, 50'd10);

    // Randomized passes against the model
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 4; i++) set_coef(i, COEF_W'($urandom));
      for (int i = 0; i < 4; i++) mux_in[i] = $urandom;
      run_pass($sformatf("rnd%0d", r), int'($urandom_range(0, 3)), r[0], model());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
